// File: rtl/bus_op_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg : shared states, opcodes and control-word decode
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned MULDIV_CYCLES_DEFAULT = 4;

  localparam logic SEL_Y    = 1'b0;
  localparam logic SEL_FOUR = 1'b1;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic r1in;
    logic r1out;
    logic r2in;
    logic r2out;
    logic yin;
    logic zin;
    logic zout;
    logic sel_y;
    logic add;
    logic sub;
    logic mul;
    logic div;
  } ctrl_t;

  function automatic logic is_muldiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic ctrl_t ctrl_decode(input state_e st, input logic [1:0] op);
    ctrl_t c;
    c       = '0;
    c.sel_y = SEL_Y;
    case (st)
      IDLE: c.ready = 1'b1;
      T1: begin
        c.busy  = 1'b1;
        c.r1out = 1'b1;
        c.yin   = 1'b1;
      end
      T2: begin
        c.busy  = 1'b1;
        c.r2out = 1'b1;
        c.zin   = 1'b1;
        c.add   = (op == OP_ADD);
        c.sub   = (op == OP_SUB);
        c.mul   = (op == OP_MUL);
        c.div   = (op == OP_DIV);
      end
      T3: begin
        c.ready = 1'b1;
        c.busy  = 1'b1;
        c.done  = 1'b1;
        c.zout  = 1'b1;
        c.r1in  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_op_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_op_sequencer_if : instruction handshake and datapath control strobes
// Rev 1.0
// ---------------------------------------------------------------------------
interface bus_op_sequencer_if;

  logic       Start;
  logic [1:0] InstructionCode;
  logic       Ready;
  logic       Busy;
  logic       Done;
  logic       R1in;
  logic       R1out;
  logic       R2in;
  logic       R2out;
  logic       Yin;
  logic       Zin;
  logic       Zout;
  logic       SelectY;
  logic       Add;
  logic       Sub;
  logic       Mul;
  logic       Div;
  logic [1:0] Step;

  modport master (
    input  Start, InstructionCode,
    output Ready, Busy, Done, R1in, R1out, R2in, R2out, Yin, Zin, Zout,
           SelectY, Add, Sub, Mul, Div, Step
  );

  modport slave (
    output Start, InstructionCode,
    input  Ready, Busy, Done, R1in, R1out, R2in, R2out, Yin, Zin, Zout,
           SelectY, Add, Sub, Mul, Div, Step
  );

endinterface
`default_nettype wire

// File: rtl/bus_op_sequencer_wait_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wait_counter : 4-bit loadable down-counter with zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module wait_counter (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic       load_i,
  input  wire logic       en_i,
  input  wire logic [3:0] load_val_i,
  output logic            zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bus_op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_op_sequencer : T1/T2/T3 control sequencer for R1 <- R1 op R2
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
  input wire logic           Clock,
  input wire logic           Reset,
  bus_op_sequencer_if.master bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       hold_zero;

  // Loaded during T1 so the count is ready on the first T2 cycle.
  wait_counter u_wait_counter (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (state_q == T1),
    .en_i       (state_q == T2),
    .load_val_i (HOLD_LOAD),
    .zero_o     (hold_zero)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = T1;
          op_d    = bus.InstructionCode;
        end
      end
      T1: state_d = T2;
      T2: begin
        if (!is_muldiv(op_q) || hold_zero) begin
          state_d = T3;
        end
      end
      T3: begin
        if (bus.Start) begin
          state_d = T1;
          op_d    = bus.InstructionCode;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ctrl_d = ctrl_decode(state_d, op_d);
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      ctrl_q  <= ctrl_decode(IDLE, OP_ADD);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.Ready   = ctrl_q.ready;
  assign bus.Busy    = ctrl_q.busy;
  assign bus.Done    = ctrl_q.done;
  assign bus.R1in    = ctrl_q.r1in;
  assign bus.R1out   = ctrl_q.r1out;
  assign bus.R2in    = ctrl_q.r2in;
  assign bus.R2out   = ctrl_q.r2out;
  assign bus.Yin     = ctrl_q.yin;
  assign bus.Zin     = ctrl_q.zin;
  assign bus.Zout    = ctrl_q.zout;
  assign bus.SelectY = ctrl_q.sel_y;
  assign bus.Add     = ctrl_q.add;
  assign bus.Sub     = ctrl_q.sub;
  assign bus.Mul     = ctrl_q.mul;
  assign bus.Div     = ctrl_q.div;
  assign bus.Step    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_op_sequencer : directed cycle-by-cycle check of the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bus_op_sequencer;

  // {Ready,Busy,Done,R1in,R1out,R2in,R2out,Yin,Zin,Zout,SelectY,Add,Sub,Mul,Div,Step}
  localparam logic [16:0] E_IDLE   = 17'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] E_T1     = 17'b0_1_0_0_1_0_0_1_0_0_0_0_0_0_0_01;
  localparam logic [16:0] E_T2_ADD = 17'b0_1_0_0_0_0_1_0_1_0_0_1_0_0_0_10;
  localparam logic [16:0] E_T2_SUB = 17'b0_1_0_0_0_0_1_0_1_0_0_0_1_0_0_10;
  localparam logic [16:0] E_T2_MUL = 17'b0_1_0_0_0_0_1_0_1_0_0_0_0_1_0_10;
  localparam logic [16:0] E_T2_DIV = 17'b0_1_0_0_0_0_1_0_1_0_0_0_0_0_1_10;
  localparam logic [16:0] E_T3     = 17'b1_1_1_1_0_0_0_0_0_1_0_0_0_0_0_11;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_fail;
  int   done_count;

  bus_op_sequencer_if bus ();

  bus_op_sequencer #(
    .MULDIV_CYCLES (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] snap();
    return {bus.Ready, bus.Busy, bus.Done, bus.R1in, bus.R1out, bus.R2in, bus.R2out,
            bus.Yin, bus.Zin, bus.Zout, bus.SelectY, bus.Add, bus.Sub, bus.Mul,
            bus.Div, bus.Step};
  endfunction

  // Advance one cycle and compare the full control word.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge Clock);
    check_value(tag, 32'(snap()), 32'(exp));
  endtask

  always @(negedge Clock) begin
    check_value("inv_bus", 32'($countones({bus.R1out, bus.R2out, bus.Zout}) <= 1), 32'd1);
    check_value("inv_op", 32'($countones({bus.Add, bus.Sub, bus.Mul, bus.Div}) <= 1), 32'd1);
    check_value("inv_r2in_sel", 32'({bus.R2in, bus.SelectY}), 32'd0);
    if (bus.Done === 1'b1) done_count++;
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_count = 0;
    Reset               = 1'b1;
    bus.Start           = 1'b0;
    bus.InstructionCode = 2'b00;

    // Add after reset
    @(negedge Clock);
    @(negedge Clock);
    check_value("reset_state", 32'(snap()), 32'(E_IDLE));
    Reset = 1'b0;
    bus.Start = 1'b1; bus.InstructionCode = 2'b00;
    cyc("add_t1", E_T1);
    bus.Start = 1'b0;
    cyc("add_t2", E_T2_ADD);
    cyc("add_t3", E_T3);
    cyc("add_idle", E_IDLE);

    // Mul with 4 hold cycles, Done 6 cycles after acceptance
    bus.Start = 1'b1; bus.InstructionCode = 2'b10;
    cyc("mul_t1", E_T1);
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mul_t2", E_T2_MUL);
    cyc("mul_t3", E_T3);
    cyc("mul_idle", E_IDLE);

    // Back-to-back sub then div with Start held high
    done_count = 0;
    bus.Start = 1'b1; bus.InstructionCode = 2'b01;
    cyc("b2b_sub_t1", E_T1);
    bus.InstructionCode = 2'b11;
    cyc("b2b_sub_t2", E_T2_SUB);
    cyc("b2b_sub_t3", E_T3);
    cyc("b2b_div_t1", E_T1);
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("b2b_div_t2", E_T2_DIV);
    cyc("b2b_div_t3", E_T3);
    cyc("b2b_idle", E_IDLE);
    check_value("b2b_done_count", 32'(done_count), 32'd2);

    // Start pulses while busy are ignored
    done_count = 0;
    bus.Start = 1'b1; bus.InstructionCode = 2'b00;
    cyc("ign_t1", E_T1);
    bus.Start = 1'b1; bus.InstructionCode = 2'b10;
    cyc("ign_t2", E_T2_ADD);
    cyc("ign_t3", E_T3);
    bus.Start = 1'b0;
    cyc("ign_idle", E_IDLE);
    cyc("ign_idle2", E_IDLE);
    check_value("ign_done_count", 32'(done_count), 32'd1);

    // Reset in the second mul hold cycle, with Start also high
    bus.Start = 1'b1; bus.InstructionCode = 2'b10;
    cyc("rst_mul_t1", E_T1);
    bus.Start = 1'b0;
    cyc("rst_mul_hold1", E_T2_MUL);
    cyc("rst_mul_hold2", E_T2_MUL);
    Reset = 1'b1; bus.Start = 1'b1;
    cyc("rst_mid_wait", E_IDLE);
    Reset = 1'b0; bus.Start = 1'b1; bus.InstructionCode = 2'b00;
    cyc("post_rst_t1", E_T1);
    bus.Start = 1'b0;
    cyc("post_rst_t2", E_T2_ADD);
    cyc("post_rst_t3", E_T3);
    cyc("post_rst_idle", E_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
